fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, instruction-memory handshake and the
// registered IF/ID payload. A small FSM (idle/fetch/hold) sequences requests,
// parks an acked word in a hold buffer while downstream is stalled, and
// defers a redirect that arrives mid-request until that request completes.
// Optional: define FETCH_STALL_CNT_EN to add the stall_cnt_out counter.
module fetch_stage #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_in,
  input  logic             redirect_in,
  input  logic [WIDTH-1:0] redirect_pc_in,
  output logic             imem_req_out,
  output logic [WIDTH-1:0] imem_addr_out,
  input  logic             imem_ack_in,
  input  logic [WIDTH-1:0] imem_data_in,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus4_out,
  output logic [WIDTH-1:0] instr_out,
  output logic             valid_out
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt_out
`endif
);

  typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] pay_pc_q, pay_pc_d;
  logic [WIDTH-1:0] pay_pc4_q, pay_pc4_d;
  logic [WIDTH-1:0] pay_instr_q, pay_instr_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] pc_plus4;

  // Wraps modulo 2^WIDTH by construction.
  assign pc_plus4 = pc_q + WIDTH'(4);

  // State and payload registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      pend_q      <= 1'b0;
      pend_pc_q   <= '0;
      hold_q      <= '0;
      pay_pc_q    <= '0;
      pay_pc4_q   <= '0;
      pay_instr_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      pend_pc_q   <= pend_pc_d;
      hold_q      <= hold_d;
      pay_pc_q    <= pay_pc_d;
      pay_pc4_q   <= pay_pc4_d;
      pay_instr_q <= pay_instr_d;
      valid_q     <= valid_d;
    end
  end

  // Next-state, PC and payload selection; redirect always beats stall.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_d       = pend_q;
    pend_pc_d    = pend_pc_q;
    hold_d       = hold_q;
    pay_pc_d     = pay_pc_q;
    pay_pc4_d    = pay_pc4_q;
    pay_instr_d  = pay_instr_q;
    valid_d      = valid_q;
    imem_req_out = 1'b0;

    unique case (state_q)
      StIdle: begin
        state_d = StFetch;
        if (redirect_in) begin
          pc_d    = redirect_pc_in;
          valid_d = 1'b0;
        end else if (!stall_in) begin
          valid_d = 1'b0;
        end
      end

      StFetch: begin
        imem_req_out = 1'b1;
        if (imem_ack_in) begin
          if (redirect_in || pend_q) begin
            // Word belongs to the old path: drop it, newest target wins.
            pc_d    = redirect_in ? redirect_pc_in : pend_pc_q;
            pend_d  = 1'b0;
            valid_d = 1'b0;
          end else if (stall_in) begin
            hold_d  = imem_data_in;
            state_d = StHold;
          end else begin
            pay_pc_d    = pc_q;
            pay_pc4_d   = pc_plus4;
            pay_instr_d = imem_data_in;
            valid_d     = 1'b1;
            pc_d        = pc_plus4;
          end
        end else begin
          // Address must stay put until ack, so park the target instead.
          if (redirect_in) begin
            pend_d    = 1'b1;
            pend_pc_d = redirect_pc_in;
            valid_d   = 1'b0;
          end else if (!stall_in) begin
            valid_d = 1'b0;
          end
        end
      end

      StHold: begin
        if (redirect_in) begin
          pc_d    = redirect_pc_in;
          valid_d = 1'b0;
          state_d = StFetch;
        end else if (!stall_in) begin
          pay_pc_d    = pc_q;
          pay_pc4_d   = pc_plus4;
          pay_instr_d = hold_q;
          valid_d     = 1'b1;
          pc_d        = pc_plus4;
          state_d     = StFetch;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign imem_addr_out = pc_q;
  assign pc_out        = pay_pc_q;
  assign pc_plus4_out  = pay_pc4_q;
  assign instr_out     = pay_instr_q;
  assign valid_out     = valid_q;

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of cycles lost to downstream stall or memory wait.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if ((stall_in || (state_q == StFetch && !imem_ack_in)) &&
                 (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt_out = stall_cnt_q;
`endif

endmodule
